// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse letter display scheduler.
package morse_pkg;

   localparam int unsigned LETTER_W = 5;
   localparam logic [LETTER_W-1:0] LETTER_MAX   = 5'd25;
   localparam logic [LETTER_W-1:0] LETTER_BLANK = 5'd31;

   typedef enum logic [1:0] {
      IDLE,
      SHOW,
      GAP
   } disp_state_e;

   typedef enum logic {
      REQ_KEY,
      REQ_DEMO
   } req_id_e;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/morse_letter_fifo.sv
// Synchronous letter FIFO; push is ignored when full, pop when empty. No bypass.
module morse_letter_fifo #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned LETTER_W   = 5
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push_i,
   input  logic [LETTER_W-1:0]           data_i,
   input  logic                          pop_i,
   output logic [LETTER_W-1:0]           data_o,
   output logic                          full_o,
   output logic                          empty_o,
   output logic [$clog2(FIFO_DEPTH):0]   count_o
);

   localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW  = AddrW + 1;

   logic [LETTER_W-1:0] mem_q [FIFO_DEPTH];
   logic [AddrW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AddrW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]     count_q, count_d;
   logic                do_push, do_pop;

   always_comb begin
      do_push  = push_i && !full_o;
      do_pop   = pop_i && !empty_o;
      wr_ptr_d = do_push ? wr_ptr_q + AddrW'(1) : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + AddrW'(1) : rd_ptr_q;
      count_d  = count_q + CntW'(do_push) - CntW'(do_pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign full_o  = (count_q == CntW'(FIFO_DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

endmodule

// File: rtl/morse_display_sched.sv
// Arbitrates keyer/demo letters into a FIFO and paces them onto the display
// with a fixed hold time followed by a blank gap.
module morse_display_sched
   import morse_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = 1000,
   parameter int unsigned GAP_CYCLES  = 200,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          key_valid_i,
   input  logic [LETTER_W-1:0]           key_letter_i,
   output logic                          key_ready_o,
   input  logic                          demo_valid_i,
   input  logic [LETTER_W-1:0]           demo_letter_i,
   output logic                          demo_ready_o,
   input  logic                          enable_i,
   output logic [LETTER_W-1:0]           letter_o,
   output logic                          show_o,
   output logic                          busy_o,
   output logic [$clog2(FIFO_DEPTH):0]   count_o,
   output logic                          err_o
);

   localparam int unsigned CntW     = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned TimerMax = max_u(HOLD_CYCLES, GAP_CYCLES);
   localparam int unsigned TimerRaw = $clog2(TimerMax);
   localparam int unsigned TimerW   = (TimerRaw == 0) ? 1 : TimerRaw;

   disp_state_e         state_q, state_d;
   logic [TimerW-1:0]   timer_q, timer_d;
   logic [LETTER_W-1:0] letter_q, letter_d;
   logic                show_q, show_d;
   logic                busy_q, busy_d;
   logic                err_q, err_d;
   req_id_e             rr_last_q, rr_last_d;

   logic                fifo_full, fifo_empty;
   logic [CntW-1:0]     fifo_count, fifo_count_nxt;
   logic [LETTER_W-1:0] fifo_head;
   logic                push, pop, accept;
   logic [LETTER_W-1:0] acc_letter;

   // Round-robin only matters on a tie: the side not granted last wins.
   always_comb begin
      key_ready_o  = !fifo_full && key_valid_i && (!demo_valid_i || rr_last_q == REQ_DEMO);
      demo_ready_o = !fifo_full && demo_valid_i && (!key_valid_i || rr_last_q == REQ_KEY);
      accept       = key_ready_o || demo_ready_o;
      acc_letter   = key_ready_o ? key_letter_i : demo_letter_i;
      push         = accept && (acc_letter <= LETTER_MAX);
      err_d        = accept && (acc_letter > LETTER_MAX);
      rr_last_d    = rr_last_q;
      if (accept) begin
         rr_last_d = key_ready_o ? REQ_KEY : REQ_DEMO;
      end
   end

   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      letter_d = letter_q;
      show_d   = show_q;
      pop      = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty && enable_i) begin
               pop      = 1'b1;
               letter_d = fifo_head;
               show_d   = 1'b1;
               timer_d  = TimerW'(HOLD_CYCLES - 1);
               state_d  = SHOW;
            end
         end
         SHOW: begin
            if (timer_q == '0) begin
               letter_d = LETTER_BLANK;
               show_d   = 1'b0;
               timer_d  = TimerW'(GAP_CYCLES - 1);
               state_d  = GAP;
            end else begin
               timer_d = timer_q - TimerW'(1);
            end
         end
         GAP: begin
            if (timer_q == '0) begin
               state_d = IDLE;
            end else begin
               timer_d = timer_q - TimerW'(1);
            end
         end
         default: begin
            state_d  = IDLE;
            letter_d = LETTER_BLANK;
            show_d   = 1'b0;
         end
      endcase
      // busy reflects the state and occupancy that will hold after this edge
      fifo_count_nxt = fifo_count + CntW'(push) - CntW'(pop);
      busy_d         = (state_d != IDLE) || (fifo_count_nxt != '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         timer_q   <= '0;
         letter_q  <= LETTER_BLANK;
         show_q    <= 1'b0;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
         rr_last_q <= REQ_DEMO;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         letter_q  <= letter_d;
         show_q    <= show_d;
         busy_q    <= busy_d;
         err_q     <= err_d;
         rr_last_q <= rr_last_d;
      end
   end

   morse_letter_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .LETTER_W   (LETTER_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .data_i  (acc_letter),
      .pop_i   (pop),
      .data_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign letter_o = letter_q;
   assign show_o   = show_q;
   assign busy_o   = busy_q;
   assign err_o    = err_q;
   assign count_o  = fifo_count;

endmodule

// File: tb/tb_morse_display_sched.sv
// Bench for morse_display_sched: queue/age model checked every cycle plus directed literals.
module tb_morse_display_sched;

   localparam int HOLD  = 4;
   localparam int GAP   = 2;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       key_valid, demo_valid, enable;
   logic [4:0] key_letter, demo_letter;
   logic       key_ready_o, demo_ready_o, show_o, busy_o, err_o;
   logic [4:0] letter_o;
   logic [2:0] count_o;

   int  n_total = 0;
   int  n_bad   = 0;
   bit  chk_en  = 1'b0;

   always #5 clk = ~clk;

   morse_display_sched #(
      .HOLD_CYCLES (HOLD),
      .GAP_CYCLES  (GAP),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .key_valid_i   (key_valid),
      .key_letter_i  (key_letter),
      .key_ready_o   (key_ready_o),
      .demo_valid_i  (demo_valid),
      .demo_letter_i (demo_letter),
      .demo_ready_o  (demo_ready_o),
      .enable_i      (enable),
      .letter_o      (letter_o),
      .show_o        (show_o),
      .busy_o        (busy_o),
      .count_o       (count_o),
      .err_o         (err_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         if (n_bad <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Model: pending letters in a queue; the displayed letter is described by its
   // age in cycles since it was popped (shown for HOLD, blank for GAP, then idle).
   int m_q[$];
   bit m_rr_demo;
   bit m_err;
   int m_age;
   int m_cur;

   function automatic bit m_key_ready();
      return (m_q.size() < DEPTH) && key_valid && (!demo_valid || m_rr_demo);
   endfunction

   function automatic bit m_demo_ready();
      return (m_q.size() < DEPTH) && demo_valid && (!key_valid || !m_rr_demo);
   endfunction

   always @(posedge clk) begin : model
      bit kr, dr;
      int acc;
      if (rst) begin
         m_q.delete();
         m_rr_demo = 1'b1;
         m_err     = 1'b0;
         m_age     = -1;
         m_cur     = 31;
      end else begin
         kr    = m_key_ready();
         dr    = m_demo_ready();
         acc   = -1;
         m_err = 1'b0;
         if (kr) begin
            acc       = int'(key_letter);
            m_rr_demo = 1'b0;
         end else if (dr) begin
            acc       = int'(demo_letter);
            m_rr_demo = 1'b1;
         end
         if (acc > 25) m_err = 1'b1;
         if (m_age < 0) begin
            if (m_q.size() > 0 && enable) begin
               m_cur = m_q.pop_front();
               m_age = 0;
            end
         end else begin
            m_age++;
            if (m_age == HOLD + GAP) m_age = -1;
         end
         if (acc >= 0 && acc <= 25) m_q.push_back(acc);
      end
   end

   always @(negedge clk) begin : compare
      bit sh;
      if (chk_en) begin
         sh = (m_age >= 0) && (m_age < HOLD);
         chk("m_show", show_o, sh);
         chk("m_letter", letter_o, sh ? m_cur : 31);
         chk("m_count", count_o, m_q.size());
         chk("m_busy", busy_o, (m_age >= 0) || (m_q.size() > 0));
         chk("m_err", err_o, m_err);
         chk("m_key_ready", key_ready_o, m_key_ready());
         chk("m_demo_ready", demo_ready_o, m_demo_ready());
      end
   end

   task automatic reset_dut();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic drain();
      key_valid  = 1'b0;
      demo_valid = 1'b0;
      enable     = 1'b1;
      for (int i = 0; i < 300 && busy_o; i++) step();
      chk("drain_idle", busy_o, 0);
   endtask

   initial begin
      int lf[5];
      int idx;
      lf = '{3, 4, 5, 6, 8};
      rst = 1'b1; key_valid = 1'b0; key_letter = '0;
      demo_valid = 1'b0; demo_letter = '0; enable = 1'b1;
      step();
      chk_en = 1'b1;
      step();
      chk("rst_letter", letter_o, 31);
      chk("rst_show", show_o, 0);
      chk("rst_count", count_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_err", err_o, 0);
      rst = 1'b0;

      // Basic display of H (7)
      key_valid = 1'b1; key_letter = 5'd7;
      #1 chk("basic_ready_c0", key_ready_o, 1);
      step();
      key_valid = 1'b0;
      #1 chk("basic_count_c1", count_o, 1);
      chk("basic_show_c1", show_o, 0);
      step();
      chk("basic_show_c2", show_o, 1);
      chk("basic_letter_c2", letter_o, 7);
      step(); step(); step();
      chk("basic_show_c5", show_o, 1);
      step();
      chk("basic_show_c6", show_o, 0);
      chk("basic_letter_c6", letter_o, 31);
      chk("basic_busy_c6", busy_o, 1);
      step(); step();
      chk("basic_busy_c8", busy_o, 0);

      // Tie arbitration from reset: keyer first, then alternating
      reset_dut();
      key_valid = 1'b1; key_letter = 5'd1;
      demo_valid = 1'b1; demo_letter = 5'd2;
      for (int c = 0; c < 30; c++) begin
         #1;
         if (c == 0) begin
            chk("tie_key_ready_c0", key_ready_o, 1);
            chk("tie_demo_ready_c0", demo_ready_o, 0);
         end
         if (c == 1) chk("tie_demo_ready_c1", demo_ready_o, 1);
         if (c == 2) chk("tie_letter_c2", letter_o, 1);
         if (c == 9) chk("tie_letter_c9", letter_o, 2);
         if (c == 16) chk("tie_letter_c16", letter_o, 1);
         if (c == 23) chk("tie_letter_c23", letter_o, 2);
         step();
      end
      drain();

      // FIFO full backpressure with display disabled
      enable = 1'b0;
      idx = 0;
      for (int c = 0; c < 10; c++) begin
         key_valid   = (idx < 5);
         key_letter  = 5'(lf[(idx < 5) ? idx : 0]);
         demo_valid  = (c == 6);
         demo_letter = 5'd9;
         #1;
         if (c == 6) begin
            chk("full_count", count_o, 4);
            chk("full_key_ready", key_ready_o, 0);
            chk("full_demo_ready", demo_ready_o, 0);
         end
         if (key_valid && key_ready_o) idx++;
         step();
      end
      demo_valid = 1'b0;
      enable     = 1'b1;
      for (int c = 0; c < 20; c++) begin
         key_valid  = (idx < 5);
         key_letter = 5'(lf[(idx < 5) ? idx : 0]);
         #1;
         if (c == 0) chk("full_ready_before_pop", key_ready_o, 0);
         if (c == 1) begin
            chk("full_first_out", letter_o, 3);
            chk("full_ready_after_pop", key_ready_o, 1);
         end
         if (key_valid && key_ready_o) idx++;
         step();
      end
      chk("full_fifth_accepted", idx, 5);
      drain();

      // Invalid letter from demo
      demo_valid = 1'b1; demo_letter = 5'd27;
      #1 chk("inv_demo_ready", demo_ready_o, 1);
      step();
      demo_valid = 1'b0;
      #1 chk("inv_err_pulse", err_o, 1);
      chk("inv_count", count_o, 0);
      step();
      chk("inv_err_clear", err_o, 0);
      chk("inv_show", show_o, 0);

      // enable_i falls while letter 0 is showing
      for (int c = 0; c < 17; c++) begin
         key_valid  = (c < 3);
         key_letter = (c == 0) ? 5'd0 : ((c == 1) ? 5'd10 : 5'd11);
         enable     = !(c >= 3 && c < 14);
         #1;
         if (c == 2) chk("en_letter_c2", letter_o, 0);
         if (c == 5) chk("en_show_c5", show_o, 1);
         if (c == 6) chk("en_show_c6", show_o, 0);
         if (c == 12) begin
            chk("en_count_c12", count_o, 2);
            chk("en_show_c12", show_o, 0);
            chk("en_busy_c12", busy_o, 1);
         end
         if (c == 15) begin
            chk("en_show_c15", show_o, 1);
            chk("en_letter_c15", letter_o, 10);
         end
         step();
      end
      drain();

      // Reset during SHOW with three queued, then a tie goes to the keyer
      for (int c = 0; c < 8; c++) begin
         key_valid  = (c < 4) || (c == 5);
         key_letter = (c < 4) ? 5'(20 + c) : 5'd1;
         demo_valid = (c == 5);
         demo_letter = 5'd2;
         rst        = (c == 4);
         #1;
         if (c == 4) begin
            chk("rstm_count_c4", count_o, 3);
            chk("rstm_letter_c4", letter_o, 20);
         end
         if (c == 5) begin
            chk("rstm_letter_c5", letter_o, 31);
            chk("rstm_show_c5", show_o, 0);
            chk("rstm_count_c5", count_o, 0);
            chk("rstm_busy_c5", busy_o, 0);
            chk("rstm_key_ready_c5", key_ready_o, 1);
            chk("rstm_demo_ready_c5", demo_ready_o, 0);
         end
         if (c == 6) chk("rstm_count_c6", count_o, 1);
         step();
      end
      rst = 1'b0;
      drain();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, expected finish before timeout");
      $fatal(1);
   end

endmodule
